fmac_sc_fifo: RTL

FMAC_SC_FIFO -- requirements
Module: fmac_sc_fifo

---
 rtl/fmac_sc_fifo_if.sv | 29 ++
 rtl/fmac_sc_fifo.sv | 136 +++++++++++++
 2 files changed

// File: rtl/fmac_sc_fifo_if.sv
// Bundles the FIFO's request/data/status signals.
//   master : drives wrreq, data, rdreq; observes q and the status flags
//   slave  : the FIFO side; receives requests, drives q and the status flags
interface fmac_sc_fifo_if #(
    parameter int WIDTH = 8,
    parameter int PTR   = 12
);
    logic             wrreq;
    logic [WIDTH-1:0] data;
    logic             rdreq;
    logic [WIDTH-1:0] q;
    logic             full;
    logic             empty;
    logic [PTR:0]     usedw;
    logic             almost_full;
    logic             almost_empty;
    logic             ovf;
    logic             udf;

    modport master (
        output wrreq, data, rdreq,
        input  q, full, empty, usedw, almost_full, almost_empty, ovf, udf
    );

    modport slave (
        input  wrreq, data, rdreq,
        output q, full, empty, usedw, almost_full, almost_empty, ovf, udf
    );
endinterface

// File: rtl/fmac_sc_fifo.sv
// Single-clock FIFO with registered status flags and sticky error flags.
//   clk  : single clock, rising edge
//   aclr : synchronous active-high reset; discards contents
//   bus  : slave side of fmac_sc_fifo_if
//          wrreq/data    write request and word
//          rdreq         read request (FWFT acknowledge when SHOWAHEAD=1)
//          q             read data (normal: 1-cycle latency, FWFT: head word)
//          full/empty    usedw == DEPTH / usedw == 0
//          usedw         words stored, 0..DEPTH
//          almost_full   usedw >= AF_LEVEL
//          almost_empty  usedw <= AE_LEVEL
//          ovf/udf       sticky write-when-full / read-when-empty
module fmac_sc_fifo #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4096,
    parameter int PTR       = 12,
    parameter int SHOWAHEAD = 0,
    parameter int AF_LEVEL  = DEPTH - 16,
    parameter int AE_LEVEL  = 16
) (
    input  logic           clk,
    input  logic           aclr,
    fmac_sc_fifo_if.slave  bus
);

    localparam logic [PTR:0]   ONE_W   = (PTR+1)'(1);
    localparam logic [PTR:0]   DEPTH_W = (PTR+1)'(DEPTH);
    localparam logic [PTR:0]   AF_W    = (PTR+1)'(AF_LEVEL);
    localparam logic [PTR:0]   AE_W    = (PTR+1)'(AE_LEVEL);
    localparam logic [PTR-1:0] ONE_P   = PTR'(1);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PTR-1:0]   wr_ptr;
    logic [PTR-1:0]   rd_ptr;
    logic [PTR-1:0]   rd_ptr_inc;
    logic [PTR:0]     usedw_r;
    logic [PTR:0]     usedw_nxt;
    logic             full_r;
    logic             empty_r;
    logic             af_r;
    logic             ae_r;
    logic             ovf_r;
    logic             udf_r;
    logic [WIDTH-1:0] q_r;
    logic             wr_acc;
    logic             rd_acc;

    // Acceptance uses the registered flags, so a full FIFO still takes a
    // read and an empty FIFO still takes a write in the same cycle.
    always_comb begin
        wr_acc     = bus.wrreq & ~full_r;
        rd_acc     = bus.rdreq & ~empty_r;
        rd_ptr_inc = rd_ptr + ONE_P;
        usedw_nxt  = usedw_r;
        if (wr_acc && !rd_acc) begin
            usedw_nxt = usedw_r + ONE_W;
        end else if (rd_acc && !wr_acc) begin
            usedw_nxt = usedw_r - ONE_W;
        end
    end

    // Storage has no reset; clearing the pointers makes old words unreachable.
    always_ff @(posedge clk) begin
        if (!aclr && wr_acc) begin
            mem[wr_ptr] <= bus.data;
        end
    end

    // Flags are computed from the next occupancy so they line up with usedw.
    always_ff @(posedge clk) begin
        if (aclr) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            usedw_r <= '0;
            full_r  <= 1'b0;
            empty_r <= 1'b1;
            af_r    <= 1'b0;
            ae_r    <= 1'b1;
            ovf_r   <= 1'b0;
            udf_r   <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + ONE_P;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr_inc;
            end
            usedw_r <= usedw_nxt;
            full_r  <= (usedw_nxt == DEPTH_W);
            empty_r <= (usedw_nxt == '0);
            af_r    <= (usedw_nxt >= AF_W);
            ae_r    <= (usedw_nxt <= AE_W);
            if (bus.wrreq && full_r) begin
                ovf_r <= 1'b1;
            end
            if (bus.rdreq && empty_r) begin
                udf_r <= 1'b1;
            end
        end
    end

    // Normal mode registers the word being read. FWFT mode keeps q loaded
    // with the head word: on a read it preloads the word behind the head
    // (or the word being written when the head was the last one), and a
    // write into an empty FIFO lands directly in q.
    always_ff @(posedge clk) begin
        if (aclr) begin
            q_r <= '0;
        end else if (SHOWAHEAD == 0) begin
            if (rd_acc) begin
                q_r <= mem[rd_ptr];
            end
        end else begin
            if (rd_acc) begin
                if (usedw_r > ONE_W) begin
                    q_r <= mem[rd_ptr_inc];
                end else if (wr_acc) begin
                    q_r <= bus.data;
                end
            end else if (wr_acc && empty_r) begin
                q_r <= bus.data;
            end
        end
    end

    assign bus.q            = q_r;
    assign bus.full         = full_r;
    assign bus.empty        = empty_r;
    assign bus.usedw        = usedw_r;
    assign bus.almost_full  = af_r;
    assign bus.almost_empty = ae_r;
    assign bus.ovf          = ovf_r;
    assign bus.udf          = udf_r;

endmodule
